// File: rtl/coin_acceptor_pkg.sv
// Shared definitions for the coin acceptor front end and the vending
// controller it feeds.
//   COIN1_VAL / COIN5_VAL : credit units carried by each coin type
//   MONEY_MAX             : controller credit ceiling, also the default
//                           depth of the pending-credit buffer
//   drain_state_t         : encoding of the Input_Money drain FSM
package coin_acceptor_pkg;

  localparam int COIN1_VAL = 1;
  localparam int COIN5_VAL = 5;
  localparam int MONEY_MAX = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2
  } drain_state_t;

endpackage

// File: rtl/coin_acceptor_debounce.sv
// coin_debounce: two-flop synchroniser, debounce counter and armed flag for
// one raw coin-slot sensor.
//   Clock, nReset : system clock, asynchronous active-low reset
//   coin_raw      : asynchronous sensor level, high while a coin passes
//   accept        : single-cycle pulse, valid in the cycle before the edge
//                   at which the debounce counter reaches DEBOUNCE
module coin_debounce #(
  parameter int DEBOUNCE = 3
) (
  input  logic Clock,
  input  logic nReset,
  input  logic coin_raw,
  output logic accept
);

  localparam logic [2:0] DB    = 3'(DEBOUNCE);
  localparam logic [2:0] DB_M1 = 3'(DEBOUNCE - 1);

  logic       sync1;
  logic       sync2;
  logic [2:0] cnt;
  logic       armed;

  // The counter value seen at an edge is the count of earlier high edges, so
  // the edge that makes it reach DEBOUNCE is the one where it equals DB-1.
  assign accept = armed && sync2 && (cnt == DB_M1);

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= 3'd0;
      armed <= 1'b0;
    end else begin
      sync1 <= coin_raw;
      sync2 <= sync1;
      if (!sync2) begin
        cnt   <= 3'd0;
        armed <= 1'b1;
      end else begin
        // Saturate so a coin stuck in the slot cannot wrap and re-accept.
        if (cnt != DB) cnt <= cnt + 3'd1;
        if (accept) armed <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/coin_acceptor.sv
// coin_acceptor: debounces the 1-unit and 5-unit coin sensors, buffers the
// accepted credit and drains it to the vending controller one unit per
// Input_Money pulse.
//   Clock, nReset  : system clock, asynchronous active-low reset
//   Coin_1, Coin_5 : raw coin sensors
//   Hold           : controller cannot take credit now
//   Money_Full     : controller credit at maximum
//   Input_Money    : registered one-cycle pulse per credit unit
//   Reject         : registered one-cycle pulse when a coin is returned
//   Pending        : buffered credit, 0..MAX_PEND
//   dbg_state      : drain FSM state
// Handshake: a unit is transferred on every cycle Input_Money is high; the
// controller throttles only through Hold/Money_Full, which are sampled solely
// at launch points, so a pulse once issued is never withdrawn.
module coin_acceptor
  import coin_acceptor_pkg::*;
#(
  parameter int DEBOUNCE = 3,
  parameter int MAX_PEND = MONEY_MAX,
  parameter int GAP      = 1
) (
  input  logic         Clock,
  input  logic         nReset,
  input  logic         Coin_1,
  input  logic         Coin_5,
  input  logic         Hold,
  input  logic         Money_Full,
  output logic         Input_Money,
  output logic         Reject,
  output logic [4:0]   Pending,
  output drain_state_t dbg_state
);

  localparam logic [5:0] MAX6   = 6'(MAX_PEND);
  localparam logic [1:0] GAP_M1 = (GAP > 0) ? 2'(GAP - 1) : 2'd0;

  logic         acc1;
  logic         acc5;
  drain_state_t state, state_d;
  logic [1:0]   gap_cnt, gap_d;
  logic [4:0]   pending;
  logic         launch_point;
  logic         dec;
  logic [5:0]   sum;
  logic         rej;

  coin_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb1 (
    .Clock    (Clock),
    .nReset   (nReset),
    .coin_raw (Coin_1),
    .accept   (acc1)
  );

  coin_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb5 (
    .Clock    (Clock),
    .nReset   (nReset),
    .coin_raw (Coin_5),
    .accept   (acc5)
  );

  always_comb begin
    launch_point = 1'b0;
    dec          = 1'b0;
    sum          = 6'd0;
    rej          = 1'b0;
    state_d      = state;
    gap_d        = gap_cnt;

    // The last cycle of GAP (or of PULSE when GAP=0) doubles as a launch
    // point so the drain sustains one unit per GAP+1 cycles.
    case (state)
      ST_IDLE:  launch_point = 1'b1;
      ST_PULSE: launch_point = (GAP == 0);
      ST_GAP:   launch_point = (gap_cnt == 2'd0);
      default:  launch_point = 1'b0;
    endcase
    dec = launch_point && (pending != 5'd0) && !Hold && !Money_Full;

    // Accept against the post-drain value; 5-unit coin has priority.
    sum = {1'b0, pending} - 6'(dec);
    if (acc5) begin
      if (sum + 6'(COIN5_VAL) <= MAX6) sum = sum + 6'(COIN5_VAL);
      else                             rej = 1'b1;
    end
    if (acc1) begin
      if (sum + 6'(COIN1_VAL) <= MAX6) sum = sum + 6'(COIN1_VAL);
      else                             rej = 1'b1;
    end

    case (state)
      ST_IDLE: begin
        if (dec) state_d = ST_PULSE;
      end
      ST_PULSE: begin
        if (GAP > 0) begin
          state_d = ST_GAP;
          gap_d   = GAP_M1;
        end else begin
          state_d = dec ? ST_PULSE : ST_IDLE;
        end
      end
      ST_GAP: begin
        if (gap_cnt == 2'd0) state_d = dec ? ST_PULSE : ST_IDLE;
        else                 gap_d   = gap_cnt - 2'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state       <= ST_IDLE;
      gap_cnt     <= 2'd0;
      pending     <= 5'd0;
      Input_Money <= 1'b0;
      Reject      <= 1'b0;
    end else begin
      state       <= state_d;
      gap_cnt     <= gap_d;
      pending     <= sum[4:0];
      Input_Money <= dec;
      Reject      <= rej;
    end
  end

  assign Pending   = pending;
  assign dbg_state = state;

endmodule

// File: tb/tb_coin_acceptor.sv
// Bench for coin_acceptor (DEBOUNCE=3, MAX_PEND=16, GAP=1). Directed coin
// sequences push the expected Input_Money / Reject events, stamped with the
// clock edge after which they must be seen, into exp_q; a monitor pops and
// compares on every output pulse. Pending is checked directly at key points.
module tb_coin_acceptor;
  import coin_acceptor_pkg::*;

  localparam logic [1:0] EV_MONEY  = 2'd1;
  localparam logic [1:0] EV_REJECT = 2'd2;

  logic         Clock;
  logic         nReset;
  logic         Coin_1;
  logic         Coin_5;
  logic         Hold;
  logic         Money_Full;
  logic         Input_Money;
  logic         Reject;
  logic [4:0]   Pending;
  drain_state_t dbg_state;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  logic [15:0] exp_q[$];

  coin_acceptor #(.DEBOUNCE(3), .MAX_PEND(16), .GAP(1)) dut (
    .Clock       (Clock),
    .nReset      (nReset),
    .Coin_1      (Coin_1),
    .Coin_5      (Coin_5),
    .Hold        (Hold),
    .Money_Full  (Money_Full),
    .Input_Money (Input_Money),
    .Reject      (Reject),
    .Pending     (Pending),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  // ---------------- driver / checker tasks ----------------
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_ev(input logic [1:0] kind, input int at_cyc);
    exp_q.push_back({kind, 14'(at_cyc)});
  endtask

  task automatic sb_pop(input logic [1:0] kind);
    logic [15:0] got;
    logic [15:0] e;
    got = {kind, 14'(cyc)};
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL sb_event: got kind=%0d cyc=%0d expected no event", kind, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e != got) begin
        failures++;
        $display("FAIL sb_event: got kind=%0d cyc=%0d expected kind=%0d cyc=%0d",
                 kind, cyc, e[15:14], e[13:0]);
      end
    end
  endtask

  // Raise the selected lines at a negedge for len edges, then idle 4 cycles.
  task automatic coin_pulse(input logic c5, input logic c1, input int len);
    Coin_5 = c5;
    Coin_1 = c1;
    repeat (len) @(negedge Clock);
    Coin_5 = 1'b0;
    Coin_1 = 1'b0;
    repeat (4) @(negedge Clock);
  endtask

  // ---------------- stimulus + monitor ----------------
  initial begin
    int t;
    nReset = 1'b0; Coin_1 = 1'b0; Coin_5 = 1'b0; Hold = 1'b0; Money_Full = 1'b0;

    fork
      forever begin
        @(negedge Clock);
        if (Input_Money) sb_pop(EV_MONEY);
        if (Reject)      sb_pop(EV_REJECT);
      end
    join_none

    repeat (3) @(negedge Clock);
    check("reset_money", int'(Input_Money), 0);
    check("reset_reject", int'(Reject), 0);
    check("reset_pending", int'(Pending), 0);
    nReset = 1'b1;
    repeat (2) @(negedge Clock);

    // Single Coin_1: accept at edge 5, one pulse after edge 6.
    t = cyc;
    push_ev(EV_MONEY, t + 6);
    Coin_1 = 1'b1;
    repeat (5) @(negedge Clock);
    check("c1_pending_at_accept", int'(Pending), 1);
    Coin_1 = 1'b0;
    @(negedge Clock);
    check("c1_money_high", int'(Input_Money), 1);
    check("c1_pending_drained", int'(Pending), 0);
    repeat (3) @(negedge Clock);

    // Coin_5: five pulses two cycles apart.
    t = cyc;
    for (int k = 0; k < 5; k++) push_ev(EV_MONEY, t + 6 + 2 * k);
    coin_pulse(1'b1, 1'b0, 5);
    repeat (8) @(negedge Clock);
    check("c5_pending_drained", int'(Pending), 0);

    // Short glitch is ignored; a long hold gives exactly one accept.
    coin_pulse(1'b0, 1'b1, 2);
    repeat (6) @(negedge Clock);
    check("glitch_pending", int'(Pending), 0);
    t = cyc;
    push_ev(EV_MONEY, t + 6);
    coin_pulse(1'b0, 1'b1, 20);
    repeat (4) @(negedge Clock);
    check("long_hold_pending", int'(Pending), 0);

    // Fill to the limit under Hold, then overflow rejects.
    Hold = 1'b1;
    for (int k = 0; k < 3; k++) coin_pulse(1'b1, 1'b0, 5);
    check("hold_pending_15", int'(Pending), 15);
    t = cyc;
    push_ev(EV_REJECT, t + 5);
    coin_pulse(1'b1, 1'b0, 5);
    check("c5_overflow_pending", int'(Pending), 15);
    coin_pulse(1'b0, 1'b1, 5);
    check("c1_fill_pending", int'(Pending), 16);
    t = cyc;
    push_ev(EV_REJECT, t + 5);
    coin_pulse(1'b0, 1'b1, 5);
    check("c1_overflow_pending", int'(Pending), 16);
    t = cyc;
    for (int k = 0; k < 16; k++) push_ev(EV_MONEY, t + 1 + 2 * k);
    Hold = 1'b0;
    repeat (34) @(negedge Clock);
    check("full_drain_pending", int'(Pending), 0);

    // Simultaneous coins at Pending=11: Coin_5 wins, Coin_1 rejected once.
    Hold = 1'b1;
    coin_pulse(1'b1, 1'b0, 5);
    coin_pulse(1'b1, 1'b0, 5);
    coin_pulse(1'b0, 1'b1, 5);
    check("pending_11", int'(Pending), 11);
    t = cyc;
    push_ev(EV_REJECT, t + 5);
    coin_pulse(1'b1, 1'b1, 5);
    check("same_edge_pending", int'(Pending), 16);
    nReset = 1'b0;
    #1;
    check("reset_discard_pending", int'(Pending), 0);
    @(negedge Clock);
    nReset = 1'b1;
    Hold = 1'b0;
    repeat (3) @(negedge Clock);

    // Reset in the middle of a drain pulse.
    t = cyc;
    push_ev(EV_MONEY, t + 6);
    Coin_5 = 1'b1;
    repeat (5) @(negedge Clock);
    Coin_5 = 1'b0;
    @(negedge Clock);
    check("mid_pulse_pending", int'(Pending), 4);
    #1 nReset = 1'b0;
    #1;
    check("async_reset_money", int'(Input_Money), 0);
    check("async_reset_pending", int'(Pending), 0);
    @(negedge Clock);
    nReset = 1'b1;
    repeat (15) @(negedge Clock);
    check("post_reset_pending", int'(Pending), 0);

    // Money_Full blocks draining until it drops.
    Money_Full = 1'b1;
    coin_pulse(1'b0, 1'b1, 5);
    repeat (4) @(negedge Clock);
    check("full_blocks_pending", int'(Pending), 1);
    t = cyc;
    push_ev(EV_MONEY, t + 1);
    Money_Full = 1'b0;
    repeat (4) @(negedge Clock);
    check("full_release_pending", int'(Pending), 0);

    // ---------------- report ----------------
    check("sb_outstanding", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
